// File: rtl/slime_physics.sv
// Player slime motion engine: heading register, x wrap, jump/fall velocity profile, platform bounce.
// Latency: every output is registered; a physics tick shows up on the clk edge that samples clk_vga=1.
// Backpressure: none; the engine never stalls and with clk_vga low only the heading register moves.
module slime_physics #(
   parameter int N_FLOORS  = 4,
   parameter int X_MAX     = 619,
   parameter int Y_GROUND  = 479,
   parameter int CEIL_Y    = 240,
   parameter int SPRITE_W  = 20,
   parameter int FLOOR_W   = 40,
   parameter int PHASE_LEN = 80,
   parameter int X_INIT    = 310,
   parameter int Y_INIT    = 379
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_vga,
   input  logic [1:0]              key,
   input  logic [10*N_FLOORS-1:0]  floor_x,
   input  logic [10*N_FLOORS-1:0]  floor_y,
   input  logic [N_FLOORS-1:0]     enable,
   output logic [9:0]              x,
   output logic [9:0]              y,
   output logic [8:0]              time_gap,
   output logic                    hit_ceiling,
   output logic                    land,
   output logic [3:0]              land_idx,
   output logic                    on_ground
);

   // Phase boundaries of the velocity profile; T_END closes the last phase.
   localparam logic [8:0]  PH1      = 9'(PHASE_LEN);
   localparam logic [8:0]  PH2      = 9'(2 * PHASE_LEN);
   localparam logic [8:0]  PH3      = 9'(3 * PHASE_LEN);
   localparam logic [8:0]  T_END    = 9'(4 * PHASE_LEN);
   localparam logic [9:0]  X_MAX_V  = 10'(X_MAX);
   localparam logic [9:0]  Y_GND_V  = 10'(Y_GROUND);
   localparam logic [9:0]  CEIL_V   = 10'(CEIL_Y);
   localparam logic [9:0]  X_INIT_V = 10'(X_INIT);
   localparam logic [9:0]  Y_INIT_V = 10'(Y_INIT);
   localparam logic [10:0] SPR_W11  = 11'(SPRITE_W);
   localparam logic [10:0] FLR_W11  = 11'(FLOOR_W);

   typedef enum logic [1:0] {H_INIT, H_LEFT, H_RIGHT} head_t;
   typedef enum logic [1:0] {V_RISE, V_FALL, V_GROUNDED} vstate_t;

   head_t         h_state;
   vstate_t       v_state;

   logic [1:0]          phase;
   logic                rise_step;
   logic                fall_step;
   logic [9:0]          x_step;
   logic [N_FLOORS-1:0] match;
   logic                hit;
   logic [3:0]          hit_idx;

   // Heading follows the key every clk, independent of the physics tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_state <= H_INIT;
      end else begin
         case (key)
            2'b10:   h_state <= H_LEFT;
            2'b01:   h_state <= H_RIGHT;
            2'b11:   h_state <= H_INIT;
            default: h_state <= h_state;
         endcase
      end
   end

   // Decode which velocity phase time_gap sits in and whether y moves this tick.
   always_comb begin
      if (time_gap < PH1)      phase = 2'd0;
      else if (time_gap < PH2) phase = 2'd1;
      else if (time_gap < PH3) phase = 2'd2;
      else                     phase = 2'd3;

      rise_step = 1'b0;
      fall_step = 1'b0;
      case (phase)
         2'd0: begin
            rise_step = 1'b1;
            fall_step = (time_gap[2:0] == 3'd0);
         end
         2'd1: begin
            rise_step = (time_gap[0] == 1'b0);
            fall_step = (time_gap[1:0] == 2'd0);
         end
         2'd2: begin
            rise_step = (time_gap[1:0] == 2'd0);
            fall_step = (time_gap[0] == 1'b0);
         end
         default: begin
            rise_step = (time_gap[2:0] == 3'd0);
            fall_step = 1'b1;
         end
      endcase
   end

   // Horizontal step for the current heading, wrapping at both screen edges.
   always_comb begin
      x_step = x;
      case (h_state)
         H_LEFT:  x_step = (x == 10'd0) ? X_MAX_V : x - 10'd1;
         H_RIGHT: x_step = (({1'b0, x} + 11'd1) > {1'b0, X_MAX_V}) ? 10'd0 : x + 10'd1;
         default: x_step = x;
      endcase
   end

   // Per-platform contact test; spans are widened to 11 bits so right edges never wrap.
   for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor
      logic [9:0]  fx;
      logic [9:0]  fy;
      logic [10:0] fx_lo;
      logic [10:0] fx_hi;
      logic [10:0] sx_lo;
      logic [10:0] sx_hi;
      logic        left_in;
      logic        right_in;

      assign fx       = floor_x[10*gi +: 10];
      assign fy       = floor_y[10*gi +: 10];
      assign fx_lo    = {1'b0, fx};
      assign fx_hi    = {1'b0, fx} + FLR_W11;
      assign sx_lo    = {1'b0, x};
      assign sx_hi    = {1'b0, x} + SPR_W11;
      assign left_in  = (sx_lo >= fx_lo) && (sx_lo <= fx_hi);
      assign right_in = (sx_hi >= fx_lo) && (sx_hi <= fx_hi);
      assign match[gi] = enable[gi] && (y == (fy - 10'd1)) && (left_in || right_in);
   end

   // Lowest-numbered matching platform wins the bounce.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 4'd0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_idx = 4'(i);
         end
      end
   end

   // Vertical state machine plus x position; everything advances only on a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= X_INIT_V;
         y           <= Y_INIT_V;
         v_state     <= V_FALL;
         time_gap    <= 9'd1;
         hit_ceiling <= 1'b0;
         land        <= 1'b0;
         land_idx    <= 4'd0;
         on_ground   <= 1'b0;
      end else begin
         land <= 1'b0;
         if (clk_vga) begin
            if (!on_ground) begin
               x <= x_step;
            end
            case (v_state)
               V_RISE: begin
                  if (time_gap < T_END) begin
                     // A ceiling-suppressed jump still runs the clock so it lasts as long as a real one.
                     if (!hit_ceiling && rise_step) begin
                        y <= y - 10'd1;
                     end
                     time_gap <= time_gap + 9'd1;
                  end else if (time_gap == T_END) begin
                     time_gap <= time_gap + 9'd1;
                  end else begin
                     v_state     <= V_FALL;
                     time_gap    <= 9'd1;
                     hit_ceiling <= 1'b0;
                  end
               end
               V_FALL: begin
                  if (y == Y_GND_V) begin
                     v_state   <= V_GROUNDED;
                     on_ground <= 1'b1;
                     time_gap  <= 9'd1;
                  end else if (hit) begin
                     v_state     <= V_RISE;
                     time_gap    <= 9'd1;
                     hit_ceiling <= (y < CEIL_V);
                     land        <= 1'b1;
                     land_idx    <= hit_idx;
                  end else if (time_gap < T_END) begin
                     if (fall_step) begin
                        y <= y + 10'd1;
                     end
                     time_gap <= time_gap + 9'd1;
                  end else if (time_gap == T_END) begin
                     time_gap <= time_gap + 9'd1;
                  end else begin
                     // Terminal velocity: one pixel per tick with the counter parked.
                     y <= y + 10'd1;
                  end
               end
               default: begin
                  v_state <= V_GROUNDED;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/slime_physics.md
# slime_physics

Parametrised motion engine for the player slime: registered x/y position, a four-phase jump/fall velocity profile, and platform bounces against N_FLOORS platforms. It sits between the key decoder / platform generator and the VGA renderer. It advances one physics step per `clk_vga` tick and adds a stop key, a grounded terminal state and a landing report.

## Interface
- N_FLOORS, 4, number of platforms checked (1..16)
- X_MAX, 619, rightmost slime x; horizontal wrap point
- Y_GROUND, 479, ground row; reaching it freezes the slime
- CEIL_Y, 240, bounce at y < CEIL_Y sets hit_ceiling
- SPRITE_W, 20, slime width in pixels
- FLOOR_W, 40, platform width in pixels
- PHASE_LEN, 80, ticks per velocity phase (T_END = 4*PHASE_LEN, must be < 511)
- X_INIT, 310 / Y_INIT, 379, reset position
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clk_vga  in  1  one-clk physics tick enable
- key  in  2  10=left, 01=right, 11=stop, 00=keep heading
- floor_x  in  10*N_FLOORS  platform i left x in bits [10i+9:10i]
- floor_y  in  10*N_FLOORS  platform i top y, same packing
- enable  in  N_FLOORS  platform i active
- x, y  out  10 each  slime top-left position
- time_gap  out  9  phase counter
- hit_ceiling  out  1  current jump is suppressed (ceiling)
- land  out  1  one-clk pulse on platform bounce
- land_idx  out  4  index of the platform bounced on
- on_ground  out  1  slime has reached Y_GROUND

## Operation
- Heading register h_state (INIT, LEFT, RIGHT) samples key every clk. 10→LEFT, 01→RIGHT, 11→INIT, 00→hold.
- On each tick: LEFT gives x = (x==0) ? X_MAX : x-1. RIGHT gives x = (x+1 > X_MAX) ? 0 : x+1. INIT holds. x is frozen while on_ground.
- Vertical FSM states: RISE, FALL, GROUNDED. Updates happen on ticks only.
- Phase k covers time_gap in [k*PHASE_LEN, (k+1)*PHASE_LEN), k=0..3. Phase 0 starts at time_gap=1.
- RISE, hit_ceiling=0: y-1 in phase 0 every tick, phase 1 when time_gap[0]==0, phase 2 when [1:0]==0, phase 3 when [2:0]==0. time_gap+1 each tick.
- RISE, hit_ceiling=1: y holds, time_gap still counts.
- RISE exit: time_gap==T_END is an idle tick with time_gap+1. When time_gap > T_END, go to FALL with time_gap=1 and hit_ceiling=0.
- FALL checks, in priority order:
  1. y==Y_GROUND → GROUNDED, on_ground=1, time_gap=1.
  2. Platform hit → bounce.
  3. Profile: y+1 in phase 0 when [2:0]==0, phase 1 when [1:0]==0, phase 2 when [0]==0, phase 3 every tick, time_gap+1. At time_gap==T_END, idle with +1. When time_gap > T_END, y+1 every tick and time_gap holds (terminal velocity).
- Platform hit for i: enable[i] && y == floor_y[i]-1 (10-bit modular) && (x in [fx, fx+FLOOR_W] || x+SPRITE_W in [fx, fx+FLOOR_W]). Bounds are inclusive; sums are computed 11-bit with no wrap. Lowest matching i wins.
- Bounce: go to RISE, y holds, time_gap=1, hit_ceiling = (y < CEIL_Y), land=1, land_idx=i.
- GROUNDED is absorbing until reset; all position/counter outputs hold.

## Timing
- All outputs are registered. The effect of a tick appears on the clk edge sampling clk_vga=1.
- land is high exactly one clk after the bounce edge, then low. land_idx holds its last value.
- key changes affect x on the first tick at or after the clk following the key sample.
- rst asserted at any time, including mid-jump or mid-tick, immediately sets:
  - x=X_INIT, y=Y_INIT
  - state FALL, h_state INIT
  - time_gap=1, hit_ceiling=0
  - land=0, land_idx=0, on_ground=0
- Release of rst is synchronous to clk.
- With no tick, no state changes except h_state.

## Test plan
- Reset with ticks running → x=310, y=379, time_gap=1, FALL, all flags 0; after 8 ticks with key=00, y=380, x=310.
- key=10 from x=1, 2 ticks → x=0 then 619; key=01 from 619 → 0; key=11 → x constant over 20 ticks.
- enable=0001, floor0 at (300,390), slime x=310 falling to y=389 → next tick RISE, land pulse 1 clk, land_idx=0, time_gap=1; 79 ticks later y=310.
- Floors 1 and 2 both matching, enable=0110 → land_idx=1; same geometry with enable[1]=0 → land_idx=2.
- Bounce at y=200 → hit_ceiling=1, y=200 for 321 ticks, then FALL with hit_ceiling=0, time_gap=1.
- Fall with no platforms to y=479 → on_ground=1, x/y frozen under key=01; rst mid-fall restores the reset values at once.
